// File: rtl/lpc_sniffer_pkg.sv
// Shared definitions for the LPC sniffer capture path.
// Holds the ring-buffer geometry, the layout of one capture slot and the
// reader state encoding. Both the memory writer and mem2serial use it.
package lpc_sniffer_pkg;

  // Each slot is 8 bytes. The ring holds 32 slots.
  localparam int SLOT_BITS = 3;
  localparam int PTR_BITS  = 5;

  // Byte offsets inside one slot. Offsets 6 and 7 are padding.
  localparam logic [SLOT_BITS-1:0] OFF_TYPE  = 3'd0;
  localparam logic [SLOT_BITS-1:0] OFF_ADDR3 = 3'd1;
  localparam logic [SLOT_BITS-1:0] OFF_ADDR2 = 3'd2;
  localparam logic [SLOT_BITS-1:0] OFF_ADDR1 = 3'd3;
  localparam logic [SLOT_BITS-1:0] OFF_ADDR0 = 3'd4;
  localparam logic [SLOT_BITS-1:0] OFF_DATA  = 3'd5;
  localparam logic [SLOT_BITS-1:0] SLOT_LAST = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FETCH,
    LATCH,
    SEND
  } reader_state_t;

endpackage

// File: rtl/mem2serial_if.sv
// Byte handshake between the ring-buffer reader and the byte transmitter.
//   tx_data  : byte offered to the transmitter
//   tx_valid : tx_data holds a byte to send
//   tx_ready : transmitter takes the byte on a clock edge where both are high
// master = byte source (mem2serial), slave = byte sink (transmitter).
interface mem2serial_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mem2serial.sv
// Ring-buffer reader for the LPC sniffer capture RAM.
// Waits for completed slots (read_ptr != write_ptr), reads the six meaningful
// bytes of each slot in order and offers them one at a time to the byte
// transmitter, optionally preceded by one SYNC_BYTE per frame.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-low
//   write_ptr  : next slot the writer will fill
//   read_ptr   : slot being read, or next slot to read
//   empty      : read_ptr == write_ptr
//   full       : write_ptr + 1 == read_ptr (mod 32)
//   ram_addr   : registered RAM read address {read_ptr, offset}
//   ram_data   : RAM read data, one cycle after ram_addr
//   tx         : byte handshake to the transmitter (master side)
//   frame_done : one-cycle pulse after the last byte of a slot is taken
module mem2serial
  import lpc_sniffer_pkg::*;
#(
  parameter bit         SYNC_EN   = 1'b1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PTR_BITS-1:0]           write_ptr,
  output logic [PTR_BITS-1:0]           read_ptr,
  output logic                          empty,
  output logic                          full,
  output logic [PTR_BITS+SLOT_BITS-1:0] ram_addr,
  input  logic [7:0]                    ram_data,
  mem2serial_if.master                  tx,
  output logic                          frame_done
);

  localparam logic [PTR_BITS-1:0]  PTR_ONE = PTR_BITS'(1);
  localparam logic [SLOT_BITS-1:0] OFF_ONE = SLOT_BITS'(1);

  reader_state_t        state;
  logic [SLOT_BITS-1:0] offset;

  // Pointer arithmetic wraps naturally at the 5-bit width.
  assign empty = (read_ptr == write_ptr);
  assign full  = ((write_ptr + PTR_ONE) == read_ptr);

  // Reader FSM. write_ptr (through empty) is only looked at in IDLE, so a
  // frame that has started always runs to completion. The RAM has one cycle
  // of read latency: FETCH lets the RAM register the address, LATCH captures
  // the returned byte into tx_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      offset      <= OFF_TYPE;
      read_ptr    <= '0;
      ram_addr    <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx.tx_valid <= 1'b0;
          if (!empty) begin
            offset   <= OFF_TYPE;
            ram_addr <= {read_ptr, OFF_TYPE};
            if (SYNC_EN) begin
              tx.tx_data  <= SYNC_BYTE;
              tx.tx_valid <= 1'b1;
              state       <= SYNC;
            end else begin
              state <= FETCH;
            end
          end
        end
        SYNC: begin
          if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          tx.tx_data  <= ram_data;
          tx.tx_valid <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
            if (offset == SLOT_LAST) begin
              read_ptr   <= read_ptr + PTR_ONE;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              offset   <= offset + OFF_ONE;
              ram_addr <= {read_ptr, offset + OFF_ONE};
              state    <= FETCH;
            end
          end
        end
        default: begin
          state       <= IDLE;
          tx.tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem2serial.sv
// Testbench for mem2serial.
// Runs two readers side by side on the same capture RAM contents, one without
// and one with the sync preamble. Expected bytes are queued when write_ptr is
// advanced and popped whenever a reader hands over a byte.
module tb_mem2serial;

  logic       clock;
  logic       reset;
  logic [4:0] write_ptr;
  logic       tx_ready;
  int         ready_mode;  // 0: ready high, 1: random, 2: ready low

  logic [7:0] mem [256];

  logic [4:0] rp0, rp1;
  logic       e0, e1, f0, f1, fd0, fd1;
  logic [7:0] ra0, ra1, rd0, rd1;

  mem2serial_if txi0 ();
  mem2serial_if txi1 ();
  assign txi0.tx_ready = tx_ready;
  assign txi1.tx_ready = tx_ready;

  mem2serial #(.SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)) dut0 (
    .clock(clock), .reset(reset), .write_ptr(write_ptr), .read_ptr(rp0),
    .empty(e0), .full(f0), .ram_addr(ra0), .ram_data(rd0), .tx(txi0),
    .frame_done(fd0));

  mem2serial #(.SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)) dut1 (
    .clock(clock), .reset(reset), .write_ptr(write_ptr), .read_ptr(rp1),
    .empty(e1), .full(f1), .ram_addr(ra1), .ram_data(rd1), .tx(txi1),
    .frame_done(fd1));

  // Synchronous-read RAM models, one per reader.
  always @(posedge clock) begin
    rd0 <= mem[ra0];
    rd1 <= mem[ra1];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard state.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         fd_times0[$];
  int         fd_times1[$];
  logic       vld[2];
  logic [7:0] dat[2];
  logic       fdn[2];
  bit         prev_stall[2];
  logic [7:0] prev_data[2];
  bit         done_due[2];
  int         nbytes[2];
  int         done_count[2];

  assign vld[0] = txi0.tx_valid;
  assign vld[1] = txi1.tx_valid;
  assign dat[0] = txi0.tx_data;
  assign dat[1] = txi1.tx_data;
  assign fdn[0] = fd0;
  assign fdn[1] = fd1;

  // tx_ready driver, updated just after every rising edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: on the falling edge, a byte with valid && ready will be taken at
  // the next rising edge. It must match the head of the queue; a stalled byte
  // must not change; frame_done must follow the last byte of each frame.
  always @(negedge clock) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        prev_stall[k] = 1'b0;
        done_due[k]   = 1'b0;
        nbytes[k]     = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (prev_stall[k]) begin
          check("hold_valid", 32'(vld[k]), 32'(1));
          check("hold_data", 32'(dat[k]), 32'(prev_data[k]));
        end
        check("frame_done", 32'(fdn[k]), 32'(done_due[k]));
        if (fdn[k]) begin
          done_count[k]++;
          if (k == 0) fd_times0.push_back(cyc);
          else        fd_times1.push_back(cyc);
        end
        done_due[k] = 1'b0;
        if (vld[k] && tx_ready) begin
          int qsize;
          logic [7:0] exp;
          qsize = (k == 0) ? q0.size() : q1.size();
          if (qsize == 0) begin
            check("extra_byte_queue_size", 32'(qsize), 32'(1));
          end else begin
            exp = (k == 0) ? q0.pop_front() : q1.pop_front();
            check("tx_byte", 32'(dat[k]), 32'(exp));
            nbytes[k]++;
            if (nbytes[k] == ((k == 0) ? 6 : 7)) begin
              done_due[k] = 1'b1;
              nbytes[k]   = 0;
            end
          end
        end
        prev_stall[k] = vld[k] && !tx_ready;
        prev_data[k]  = dat[k];
      end
    end
  end

  task automatic load_slot(input logic [4:0] slot, input logic [47:0] bytes);
    for (int off = 0; off < 6; off++)
      mem[{slot, 3'(off)}] = bytes[47 - 8*off -: 8];
  endtask

  task automatic push_frame(input logic [4:0] slot);
    q1.push_back(8'hA5);
    for (int off = 0; off < 6; off++) begin
      q0.push_back(mem[{slot, 3'(off)}]);
      q1.push_back(mem[{slot, 3'(off)}]);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] wp);
    @(posedge clock);
    #1;
    write_ptr = wp;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n < budget && !(q0.size() == 0 && q1.size() == 0 && e0 && e1)) begin
      @(negedge clock);
      n++;
    end
    check("wait_done_in_budget", 32'(n < budget), 32'(1));
    repeat (2) @(negedge clock);
  endtask

  task automatic checkOutput(input logic [4:0] exp_rp, input int exp_done);
    check("read_ptr0", 32'(rp0), 32'(exp_rp));
    check("read_ptr1", 32'(rp1), 32'(exp_rp));
    check("empty0", 32'(e0), 32'(1));
    check("empty1", 32'(e1), 32'(1));
    check("done_count0", 32'(done_count[0]), 32'(exp_done));
    check("done_count1", 32'(done_count[1]), 32'(exp_done));
  endtask

  typedef struct {
    logic [4:0]  slot;
    logic [47:0] bytes;
    int          mode;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int frames;
    vecs[0] = '{slot: 5'd1, bytes: 48'h01_12_34_56_78_9A, mode: 0};
    vecs[1] = '{slot: 5'd2, bytes: 48'h0F_FF_FF_FF_FF_FF, mode: 1};
    vecs[2] = '{slot: 5'd3, bytes: 48'h00_00_00_00_00_00, mode: 2};
    vecs[3] = '{slot: 5'd4, bytes: 48'h0A_DE_AD_BE_EF_C3, mode: 1};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    done_count[0] = 0;
    done_count[1] = 0;
    ready_mode = 0;
    write_ptr  = 5'd0;
    reset      = 1'b0;

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_read_ptr", 32'(rp0), 32'(0));
    check("rst_ram_addr", 32'(ra1), 32'(0));
    check("rst_tx_data", 32'(txi1.tx_data), 32'(0));
    check("rst_tx_valid", 32'(txi1.tx_valid), 32'(0));
    check("rst_frame_done", 32'(fd1), 32'(0));
    check("rst_empty", 32'(e0), 32'(1));
    check("rst_full", 32'(f0), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;

    // First frame, with latency of both variants.
    load_slot(5'd0, 48'h03_FE_D0_00_80_5A);
    applyStimulus(5'd1);
    push_frame(5'd0);
    @(negedge clock);
    check("lat_n0_valid0", 32'(txi0.tx_valid), 32'(0));
    check("lat_n0_valid1", 32'(txi1.tx_valid), 32'(0));
    @(negedge clock);
    check("lat_sync_valid", 32'(txi1.tx_valid), 32'(1));
    check("lat_sync_data", 32'(txi1.tx_data), 32'(8'hA5));
    check("lat_n1_valid0", 32'(txi0.tx_valid), 32'(0));
    check("lat_n1_addr0", 32'(ra0), 32'(8'h00));
    @(negedge clock);
    check("lat_n2_valid0", 32'(txi0.tx_valid), 32'(0));
    @(negedge clock);
    check("lat_n3_valid0", 32'(txi0.tx_valid), 32'(1));
    check("lat_n3_data0", 32'(txi0.tx_data), 32'(8'h03));
    wait_done(100);
    checkOutput(5'd1, 1);
    frames = 1;

    // Table of single frames under different ready patterns.
    for (int i = 0; i < 4; i++) begin
      load_slot(vecs[i].slot, vecs[i].bytes);
      ready_mode = vecs[i].mode;
      push_frame(vecs[i].slot);
      applyStimulus(vecs[i].slot + 5'd1);
      if (vecs[i].mode == 2) begin
        repeat (20) @(negedge clock);
        check("stall_valid0", 32'(txi0.tx_valid), 32'(1));
        check("stall_valid1", 32'(txi1.tx_valid), 32'(1));
        ready_mode = 0;
      end
      wait_done(400);
      ready_mode = 0;
      frames++;
      checkOutput(vecs[i].slot + 5'd1, frames);
    end

    // Three slots at once: back-to-back with one IDLE cycle between frames.
    fd_times0.delete();
    fd_times1.delete();
    for (int s = 5; s < 8; s++) push_frame(5'(s));
    applyStimulus(5'd8);
    wait_done(200);
    frames += 3;
    checkOutput(5'd8, frames);
    check("b2b_count0", 32'(fd_times0.size()), 32'(3));
    check("b2b_count1", 32'(fd_times1.size()), 32'(3));
    if (fd_times0.size() == 3 && fd_times1.size() == 3) begin
      check("b2b_gap0a", 32'(fd_times0[1] - fd_times0[0]), 32'(19));
      check("b2b_gap0b", 32'(fd_times0[2] - fd_times0[1]), 32'(19));
      check("b2b_gap1a", 32'(fd_times1[1] - fd_times1[0]), 32'(20));
      check("b2b_gap1b", 32'(fd_times1[2] - fd_times1[1]), 32'(20));
    end

    // Bulk run up to slot 31 with random ready.
    ready_mode = 1;
    for (int s = 8; s < 31; s++) push_frame(5'(s));
    applyStimulus(5'd31);
    wait_done(2000);
    ready_mode = 0;
    frames += 23;
    checkOutput(5'd31, frames);

    // Slot 31 and pointer wrap.
    push_frame(5'd31);
    applyStimulus(5'd0);
    @(negedge clock);
    @(negedge clock);
    check("wrap_first_addr", 32'(ra0), 32'(8'hF8));
    wait_done(100);
    frames++;
    checkOutput(5'd0, frames);
    check("wrap_last_addr0", 32'(ra0), 32'(8'hFD));
    check("wrap_last_addr1", 32'(ra1), 32'(8'hFD));

    // Full indication, then reset in the middle of offset 3.
    load_slot(5'd0, 48'h03_FE_D0_00_80_5A);
    push_frame(5'd0);
    applyStimulus(5'd31);
    @(negedge clock);
    check("full0", 32'(f0), 32'(1));
    check("full1", 32'(f1), 32'(1));
    check("full_empty0", 32'(e0), 32'(0));
    begin
      int n = 0;
      while (n < 100 && !(ra0 == 8'h03 && !txi0.tx_valid)) begin
        @(negedge clock);
        n++;
      end
      check("reach_offset3", 32'(n < 100), 32'(1));
    end
    @(posedge clock);
    #1;
    ready_mode = 2;
    @(negedge clock);
    @(negedge clock);
    check("mid_valid0", 32'(txi0.tx_valid), 32'(1));
    check("mid_addr0", 32'(ra0), 32'(8'h03));
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_valid0", 32'(txi0.tx_valid), 32'(0));
    check("midrst_valid1", 32'(txi1.tx_valid), 32'(0));
    check("midrst_read_ptr0", 32'(rp0), 32'(0));
    check("midrst_ram_addr0", 32'(ra0), 32'(0));
    write_ptr  = 5'd1;
    ready_mode = 0;
    repeat (3) @(negedge clock);
    check("midrst_empty0", 32'(e0), 32'(0));
    check("midrst_full0", 32'(f0), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    push_frame(5'd0);
    wait_done(100);
    frames++;
    checkOutput(5'd1, frames);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem2serial.md
# mem2serial

Ring-buffer reader for the LPC sniffer capture RAM. Detects completed 8-byte slots (filled by the LPC-to-memory writer), reads the six meaningful bytes of each slot in order and hands them one at a time to the downstream byte transmitter over a valid/ready handshake. Owns the read pointer of the ring buffer and reports empty/full status so the writer side can pick its next slot.

## Interface

Parameters:
- SYNC_EN, 1, when 1 each frame is preceded by one SYNC_BYTE
- SYNC_BYTE, 8'hA5, preamble byte value

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low
- write_ptr  in  5  next slot the writer will fill; synchronous to clock; advanced only after a frame is complete
- read_ptr  out  5  slot currently being read or next to read
- empty  out  1  combinational, read_ptr == write_ptr
- full  out  1  combinational, write_ptr + 1 == read_ptr (mod 32)
- ram_addr  out  8  registered RAM read address {read_ptr, offset[2:0]}
- ram_data  in  8  RAM read data, synchronous read, valid the cycle after ram_addr is presented
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- frame_done  out  1  one-cycle pulse when last byte of a slot is accepted

## Operation

- Slot layout (offset: content): 0 cycle type/dir in [3:0], [7:4]=0; 1..4 address bytes [31:24]..[7:0]; 5 data. Offsets 6, 7 never read.
- Byte order on tx: [SYNC_BYTE if SYNC_EN], offset 0,1,2,3,4,5.
- States: IDLE, SYNC, FETCH, LATCH, SEND.
- IDLE: tx_valid=0. If !empty: go SYNC (SYNC_EN=1) or FETCH (SYNC_EN=0); offset<=0, ram_addr<={read_ptr,3'd0}.
- SYNC: tx_data=SYNC_BYTE, tx_valid=1; on tx_valid&&tx_ready -> FETCH.
- FETCH: ram_addr stable; RAM registers read -> LATCH.
- LATCH: tx_data<=ram_data, tx_valid<=1 -> SEND.
- SEND: hold tx_data/tx_valid until tx_ready sampled high. On accept: offset==5 -> read_ptr<=read_ptr+1, frame_done<=1, tx_valid<=0, IDLE; else offset<=offset+1, ram_addr<={read_ptr,offset+1}, tx_valid<=0, FETCH.
- Pointer arithmetic modulo 32; read_ptr 31 wraps to 0.
- write_ptr changes are observed only in IDLE; a frame in progress always completes.
- Writer must never lap the reader; block does not detect overrun. full is provided for that purpose.

## Timing

- Reset values: read_ptr=0, ram_addr=0, tx_data=0, tx_valid=0, frame_done=0, state IDLE; empty=1 and full=0 when write_ptr=0.
- Reset mid-frame: frame discarded, read_ptr not advanced beyond its pre-reset value is not required — it returns to 0.
- Transfer occurs on rising edge with tx_valid&&tx_ready; tx_data must not change while tx_valid=1 and tx_ready=0.
- tx_ready high in IDLE/FETCH/LATCH: no effect.
- Latency, SYNC_EN=0, tx_ready tied high: edge detecting !empty -> tx_valid high 3 edges later; 3 cycles per byte; frame = 18 cycles IDLE to IDLE plus 1 IDLE cycle.
- SYNC_EN=1: SYNC byte valid 1 edge after detection; add 1 cycle per frame.
- tx_ready low: stall in SEND/SYNC indefinitely, no timeout.
- frame_done high exactly the cycle after final accept; read_ptr/empty update same edge.
- Back-to-back slots: at most one IDLE cycle between frames.

## Structure

- Shared package lpc_sniffer_pkg: slot offset constants (OFF_TYPE=0, OFF_ADDR3..OFF_ADDR0=1..4, OFF_DATA=5, SLOT_LAST=5), SLOT_BITS=3, PTR_BITS=5, state enum.
- Single module, no sub-module; byte transmitter (UART) is a separate downstream block.

## Test plan

- Preload slot 0 with 03,FE,D0,00,80,5A; write_ptr 0->1, tx_ready=1, SYNC_EN=0 -> tx bytes 03,FE,D0,00,80,5A, frame_done once, read_ptr=1, empty=1.
- SYNC_EN=1, same slot -> A5 then the six bytes; first valid 1 cycle after detection.
- tx_ready toggled randomly/held low 20 cycles -> no byte lost, duplicated or changed while valid.
- read_ptr=31, write_ptr 31->0 -> slot 31 sent using ram_addr F8..FD, read_ptr wraps to 0.
- write_ptr advanced by 3 at once -> three frames back-to-back, one IDLE cycle between; full asserted when write_ptr=read_ptr-1.
- Reset asserted during offset 3 -> tx_valid=0 immediately, read_ptr=0, after release frame restarts from offset 0.
